handshake_arbiter: RTL and testbench

HANDSHAKE_ARBITER -- requirements
Module: handshake_arbiter

---
 rtl/handshake_arbiter.sv | 177 +++++++++++++++++
 tb/tb_handshake_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_arbiter.sv
// handshake_arbiter
//   Round-robin arbiter that multiplexes N_REQ valid/ready requesters onto one
//   shared valid/ready slave port. A grant lasts up to BURST_LEN beats and
//   ends early when the granted requester drops valid. Payload and handshake
//   pass through combinationally while granted. The arbitration decision costs
//   one IDLE cycle between grants.
//
//   Ports
//     sys_clk     clock, rising edge
//     rst         asynchronous active-high reset
//     valid_up    [N_REQ]          per-requester valid
//     data_up     [N_REQ*DATA_W]   flat payload, requester i at [i*DATA_W +: DATA_W]
//     ready_up    [N_REQ]          per-requester ready (only the granted bit may be set)
//     valid_down                   valid toward the slave
//     data_down   [DATA_W]         payload toward the slave
//     ready_down                   ready from the slave
//     grant_id    [clog2(N_REQ)]   currently granted index
//     busy                         high while a grant is held

// Per-requester slice: decodes whether this requester owns the grant and
// gates its handshake/payload onto the shared OR-bus.
module handshake_arbiter_lane #(
  parameter int DATA_W = 3,
  parameter int GID_W  = 2,
  parameter int IDX    = 0
) (
  input  logic              grant_active,
  input  logic [GID_W-1:0]  g,
  input  logic              ready_down,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              sel_valid,
  output logic [DATA_W-1:0] sel_data
);
  logic sel;

  assign sel       = grant_active && (g == GID_W'(IDX));
  assign ready     = sel & ready_down;
  assign sel_valid = sel & valid;
  assign sel_data  = sel ? data : '0;
endmodule

module handshake_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 3,
  parameter int BURST_LEN = 4
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          valid_up,
  input  logic [N_REQ*DATA_W-1:0]   data_up,
  output logic [N_REQ-1:0]          ready_up,
  output logic                      valid_down,
  output logic [DATA_W-1:0]         data_down,
  input  logic                      ready_down,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy
);
  localparam int GID_W = $clog2(N_REQ);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);
  localparam logic [GID_W-1:0] LAST_RST = GID_W'(N_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [GID_W-1:0] g, g_nxt;
  logic [GID_W-1:0] last, last_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic [GID_W-1:0] win;

  logic                           grant_active;
  logic [N_REQ-1:0]               sel_valid;
  logic [N_REQ-1:0][DATA_W-1:0]   sel_data;
  logic                           vg;
  logic                           beat_done;

  assign grant_active = (state == GRANT);

  // Lane array: each slice owns its own grant decode and output gating.
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    handshake_arbiter_lane #(
      .DATA_W (DATA_W),
      .GID_W  (GID_W),
      .IDX    (i)
    ) u_lane (
      .grant_active (grant_active),
      .g            (g),
      .ready_down   (ready_down),
      .valid        (valid_up[i]),
      .data         (data_up[i*DATA_W +: DATA_W]),
      .ready        (ready_up[i]),
      .sel_valid    (sel_valid[i]),
      .sel_data     (sel_data[i])
    );
  end

  // At most one lane is selected, so a plain OR acts as the output mux.
  always_comb begin
    data_down = '0;
    for (int i = 0; i < N_REQ; i++) data_down = data_down | sel_data[i];
  end

  assign vg         = |sel_valid;
  assign valid_down = vg;
  assign busy       = grant_active;
  assign grant_id   = g;
  assign beat_done  = vg & ready_down;

  // Round-robin pick: scan last+1 .. last+N_REQ, so 'last' itself is the
  // lowest priority and wraps naturally back to index 0 after N_REQ-1.
  always_comb begin
    int  idx;
    logic found;
    win   = last;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && valid_up[idx]) begin
        win   = GID_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    g_nxt        = g;
    last_nxt     = last;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (|valid_up) begin
          state_nxt    = GRANT;
          g_nxt        = win;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (!vg) begin
          // Requester withdrew: release the grant, keep 'last' as-is.
          state_nxt    = IDLE;
          beat_cnt_nxt = '0;
        end else if (beat_done) begin
          last_nxt = g;
          if (beat_cnt == CNT_MAX) begin
            state_nxt    = IDLE;
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
        // valid without ready: hold everything so the beat stays stable.
      end
      default: begin
        state_nxt    = IDLE;
        beat_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      g        <= '0;
      last     <= LAST_RST;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      g        <= g_nxt;
      last     <= last_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_handshake_arbiter.sv
module tb_handshake_arbiter;
  localparam int N  = 4;
  localparam int W  = 3;
  localparam int BL = 4;
  localparam int GW = 2;

  logic             sys_clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     valid_up = '0;
  logic [N*W-1:0]   data_up = '0;
  logic             ready_down = 1'b0;
  logic [N-1:0]     ready_up;
  logic             valid_down;
  logic [W-1:0]     data_down;
  logic [GW-1:0]    grant_id;
  logic             busy;

  handshake_arbiter #(.N_REQ(N), .DATA_W(W), .BURST_LEN(BL)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .valid_up   (valid_up),
    .data_up    (data_up),
    .ready_up   (ready_up),
    .valid_down (valid_down),
    .data_down  (data_down),
    .ready_down (ready_down),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic          vd;
    logic [W-1:0]  dd;
    logic [N-1:0]  ru;
    logic          busy;
    logic [GW-1:0] gid;
  } exp_t;

  typedef struct {
    int           id;
    logic [W-1:0] d;
  } beat_t;

  exp_t  exp_q[$];
  beat_t beat_q[$];
  int    order_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    log_on = 1'b0;

  // Reference model: who owns the slave (-1 = nobody), beats served in this
  // grant, last requester that completed a beat, and the displayed grant index.
  int owner = -1;
  int beats = 0;
  int mlast = N - 1;
  int mg    = 0;

  function automatic int rr_pick(input logic [N-1:0] v, input int from);
    for (int k = 1; k <= N; k++)
      if (v[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] vu, input logic [N*W-1:0] du,
                            input logic rd, input logic r);
    exp_t e;
    beat_t b;
    e = '0;
    if (r) begin
      owner = -1; beats = 0; mlast = N - 1; mg = 0;
    end else if (owner < 0) begin
      e.gid = GW'(mg);
      if (vu != '0) begin
        owner = rr_pick(vu, mlast);
        mg    = owner;
        beats = 0;
      end
    end else begin
      e.busy = 1'b1;
      e.gid  = GW'(owner);
      e.vd   = vu[owner];
      e.dd   = du[owner*W +: W];
      if (rd) e.ru[owner] = 1'b1;
      if (!vu[owner]) begin
        owner = -1;
      end else if (rd) begin
        b.id = owner;
        b.d  = du[owner*W +: W];
        beat_q.push_back(b);
        mlast = owner;
        beats++;
        if (beats == BL) owner = -1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic [N-1:0] vu, input logic [N*W-1:0] du,
                       input logic rd, input logic r);
    @(posedge sys_clk);
    #1;
    valid_up = vu; data_up = du; ready_down = rd; rst = r;
    model_step(vu, du, rd, r);
  endtask

  // Reset raised mid-cycle while a grant is stalled: outputs must drop at once.
  task automatic mid_reset(input logic [N-1:0] vu, input logic [N*W-1:0] du);
    @(posedge sys_clk);
    #1;
    valid_up = vu; data_up = du; ready_down = 1'b0; rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({valid_down, data_down, ready_up, busy, grant_id} != '0) begin
      errors++;
      $display("FAIL async_reset got vd=%b dd=%b ru=%b busy=%b gid=%0d want all zero",
               valid_down, data_down, ready_up, busy, grant_id);
    end
    model_step(vu, du, 1'b0, 1'b1);
  endtask

  // Monitor: pops one expectation per sampled cycle, and one expected beat
  // whenever the DUT presents a completed transfer.
  initial begin
    exp_t  e, act;
    beat_t b;
    bit    prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = {valid_down, data_down, ready_up, busy, grant_id};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got vd=%b dd=%b ru=%b busy=%b gid=%0d want vd=%b dd=%b ru=%b busy=%b gid=%0d",
                   $time, act.vd, act.dd, act.ru, act.busy, act.gid,
                   e.vd, e.dd, e.ru, e.busy, e.gid);
        end
        if (valid_down && ready_down) begin
          checks++;
          if (beat_q.size() == 0) begin
            errors++;
            $display("FAIL beat_extra t=%0t got id=%0d data=%b want no beat", $time, grant_id, data_down);
          end else begin
            b = beat_q.pop_front();
            if (b.id != int'(grant_id) || b.d !== data_down) begin
              errors++;
              $display("FAIL beat t=%0t got id=%0d data=%b want id=%0d data=%b",
                       $time, grant_id, data_down, b.id, b.d);
            end
          end
        end
      end
      if (log_on && busy && !prev_busy) order_q.push_back(int'(grant_id));
      prev_busy = busy;
    end
  end

  initial begin
    logic [N-1:0]   vu;
    logic [N*W-1:0] du;
    int             want_order[5];
    want_order = '{0, 1, 2, 3, 0};

    // Reset state
    cycle('0, '0, 1'b0, 1'b1);
    cycle('0, '0, 1'b0, 1'b1);

    // Two requesters 0 and 2, slave always ready
    for (int i = 0; i < 14; i++) cycle(4'b0101, (N*W)'($urandom), 1'b1, 1'b0);

    // Lone requester 1, full bursts separated by one idle cycle
    cycle('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) cycle(4'b0010, (N*W)'($urandom), 1'b1, 1'b0);

    // Requester 3 stalled by the slave for 5 cycles with payload 101
    cycle('0, '0, 1'b0, 1'b1);
    du = 12'b101_000_000_000;
    cycle(4'b1000, du, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(4'b1000, du, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b1000, du, 1'b1, 1'b0);

    // All four requesting from reset: rotation 0,1,2,3,0
    cycle('0, '0, 1'b0, 1'b1);
    @(negedge sys_clk);
    log_on = 1'b1;
    for (int i = 0; i < 26; i++) cycle(4'b1111, (N*W)'($urandom), 1'b1, 1'b0);
    @(negedge sys_clk);
    #1;
    log_on = 1'b0;
    checks++;
    if (order_q.size() != 5) begin
      errors++;
      $display("FAIL rr_order_len got %0d want 5", order_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (order_q[i] != want_order[i]) begin
          errors++;
          $display("FAIL rr_order[%0d] got %0d want %0d", i, order_q[i], want_order[i]);
        end
      end
    end

    // Requester 2 drops valid after 2 beats, 0 and 1 pending
    cycle('0, '0, 1'b0, 1'b1);
    cycle(4'b0100, (N*W)'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cycle(4'b0111, (N*W)'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(4'b0011, (N*W)'($urandom), 1'b1, 1'b0);

    // Reset during a stalled grant, then lowest pending index wins
    cycle('0, '0, 1'b0, 1'b1);
    cycle(4'b0110, (N*W)'($urandom), 1'b1, 1'b0);
    cycle(4'b0110, (N*W)'($urandom), 1'b1, 1'b0);
    cycle(4'b0110, (N*W)'($urandom), 1'b0, 1'b0);
    mid_reset(4'b0110, (N*W)'($urandom));
    for (int i = 0; i < 3; i++) cycle(4'b0110, (N*W)'($urandom), 1'b1, 1'b0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      for (int j = 0; j < N; j++) vu[j] = ($urandom_range(0, 99) < 70);
      cycle(vu, (N*W)'($urandom), $urandom_range(0, 99) < 65,
            $urandom_range(0, 99) == 0);
    end

    cycle('0, '0, 1'b0, 1'b0);
    @(negedge sys_clk);
    #1;
    checks++;
    if (beat_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got beats=%0d cycles=%0d left want 0", beat_q.size(), exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
